// File: rtl/sound_sequencer_pkg.sv
// Shared definitions for the sound-effect sequencer: effect codes, FSM states,
// note ROM layout, note frequencies and the half-period derivation.
package sound_sequencer_pkg;

  typedef enum logic [1:0] {
    SFX_PLACE = 2'd0,
    SFX_WIN   = 2'd1,
    SFX_DRAW  = 2'd2,
    SFX_ERROR = 2'd3
  } sfx_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam int unsigned ROM_AW = 4;

  localparam logic [ROM_AW-1:0] BASE_PLACE = 4'd0;
  localparam logic [ROM_AW-1:0] BASE_WIN   = 4'd1;
  localparam logic [ROM_AW-1:0] BASE_DRAW  = 4'd5;
  localparam logic [ROM_AW-1:0] BASE_ERROR = 4'd8;

  localparam int unsigned F_REST = 0;
  localparam int unsigned F_A3   = 220;
  localparam int unsigned F_A4   = 440;
  localparam int unsigned F_C5   = 523;
  localparam int unsigned F_E5   = 659;
  localparam int unsigned F_G5   = 784;
  localparam int unsigned F_C6   = 1047;

  // A zero half-period encodes a rest.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned freq_hz);
    if (freq_hz == 0) begin
      return 0;
    end else begin
      return clk_hz / (2 * freq_hz);
    end
  endfunction

  function automatic logic [ROM_AW-1:0] sfx_base(input logic [1:0] sfx);
    case (sfx)
      SFX_PLACE: return BASE_PLACE;
      SFX_WIN:   return BASE_WIN;
      SFX_DRAW:  return BASE_DRAW;
      SFX_ERROR: return BASE_ERROR;
      default:   return BASE_PLACE;
    endcase
  endfunction

endpackage

// File: rtl/sound_sequencer_note_rom.sv
// Note ROM for the sound sequencer: 16 entries of {half-period, duration in ticks,
// last-note flag}; half-periods are derived from CLK_HZ at elaboration.
module sound_sequencer_note_rom
  import sound_sequencer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned DIV_W  = 18,
  parameter int unsigned DUR_W  = 10
) (
  input  logic [ROM_AW-1:0] addr_i,
  output logic [DIV_W-1:0]  hp_o,
  output logic [DUR_W-1:0]  dur_o,
  output logic              last_o
);

  localparam logic [DIV_W-1:0] HP_REST = DIV_W'(half_period(CLK_HZ, F_REST));
  localparam logic [DIV_W-1:0] HP_A3   = DIV_W'(half_period(CLK_HZ, F_A3));
  localparam logic [DIV_W-1:0] HP_A4   = DIV_W'(half_period(CLK_HZ, F_A4));
  localparam logic [DIV_W-1:0] HP_C5   = DIV_W'(half_period(CLK_HZ, F_C5));
  localparam logic [DIV_W-1:0] HP_E5   = DIV_W'(half_period(CLK_HZ, F_E5));
  localparam logic [DIV_W-1:0] HP_G5   = DIV_W'(half_period(CLK_HZ, F_G5));
  localparam logic [DIV_W-1:0] HP_C6   = DIV_W'(half_period(CLK_HZ, F_C6));

  // Effect table lookup; unused slots read as a terminating rest.
  always_comb begin
    hp_o   = '0;
    dur_o  = '0;
    last_o = 1'b1;
    case (addr_i)
      BASE_PLACE:          begin hp_o = HP_C5;   dur_o = DUR_W'(50);  last_o = 1'b1; end
      BASE_WIN:            begin hp_o = HP_C5;   dur_o = DUR_W'(100); last_o = 1'b0; end
      BASE_WIN + 4'd1:     begin hp_o = HP_E5;   dur_o = DUR_W'(100); last_o = 1'b0; end
      BASE_WIN + 4'd2:     begin hp_o = HP_G5;   dur_o = DUR_W'(100); last_o = 1'b0; end
      BASE_WIN + 4'd3:     begin hp_o = HP_C6;   dur_o = DUR_W'(300); last_o = 1'b1; end
      BASE_DRAW:           begin hp_o = HP_A4;   dur_o = DUR_W'(200); last_o = 1'b0; end
      BASE_DRAW + 4'd1:    begin hp_o = HP_REST; dur_o = DUR_W'(100); last_o = 1'b0; end
      BASE_DRAW + 4'd2:    begin hp_o = HP_A4;   dur_o = DUR_W'(200); last_o = 1'b1; end
      BASE_ERROR:          begin hp_o = HP_A3;   dur_o = DUR_W'(250); last_o = 1'b1; end
      default:             begin hp_o = '0;      dur_o = '0;          last_o = 1'b1; end
    endcase
  end

endmodule

// File: rtl/sound_sequencer.sv
// Sound-effect sequencer: plays ROM note lists as a square wave with req/busy/done.
// Optional SFX_MUTE_EN adds a mute_i input that silences speaker_out_o only.
module sound_sequencer
  import sound_sequencer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned DIV_W   = 18,
  parameter int unsigned DUR_W   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic [1:0] sfx_i,
`ifdef SFX_MUTE_EN
  input  logic       mute_i,
`endif
  output logic       busy_o,
  output logic       done_o,
  output logic       speaker_out_o
);

  localparam int unsigned TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int unsigned TICK_W   = $clog2(TICK_CYC + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);

  state_e              state_q;
  logic [ROM_AW-1:0]   addr_q;
  logic [DIV_W-1:0]    hp_q;
  logic [DUR_W-1:0]    dur_q;
  logic                last_q;
  logic [TICK_W-1:0]   tick_q;
  logic [DUR_W-1:0]    dur_cnt_q;
  logic [DIV_W-1:0]    hp_cnt_q;
  logic                busy_q;
  logic                done_q;
  logic                spk_q;

  logic [DIV_W-1:0]    rom_hp_s;
  logic [DUR_W-1:0]    rom_dur_s;
  logic                rom_last_s;
  logic                tick_end_s;
  logic                note_end_s;
  logic                hp_wrap_s;
  logic                spk_d;
  logic                mute_s;

  sound_sequencer_note_rom #(
    .CLK_HZ (CLK_HZ),
    .DIV_W  (DIV_W),
    .DUR_W  (DUR_W)
  ) u_rom (
    .addr_i (addr_q),
    .hp_o   (rom_hp_s),
    .dur_o  (rom_dur_s),
    .last_o (rom_last_s)
  );

`ifdef SFX_MUTE_EN
  assign mute_s = mute_i;
`else
  assign mute_s = 1'b0;
`endif

  assign tick_end_s = (tick_q == TICK_LAST);
  assign note_end_s = tick_end_s && (dur_cnt_q == dur_q - DUR_W'(1));
  assign hp_wrap_s  = (hp_cnt_q == hp_q - DIV_W'(1));
  // A rest (hp==0) holds the line low; otherwise toggle on half-period wrap.
  assign spk_d      = (hp_q == '0) ? 1'b0 : (hp_wrap_s ? ~spk_q : spk_q);

  // Sequencer FSM with its counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      hp_q      <= '0;
      dur_q     <= '0;
      last_q    <= 1'b0;
      tick_q    <= '0;
      dur_cnt_q <= '0;
      hp_cnt_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      spk_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          spk_q  <= 1'b0;
          if (req_i) begin
            addr_q  <= sfx_base(sfx_i);
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          hp_q      <= rom_hp_s;
          dur_q     <= rom_dur_s;
          last_q    <= rom_last_s;
          tick_q    <= '0;
          dur_cnt_q <= '0;
          hp_cnt_q  <= '0;
          spk_q     <= 1'b0;
          state_q   <= ST_PLAY;
        end
        ST_PLAY: begin
          spk_q    <= spk_d & ~mute_s;
          hp_cnt_q <= hp_wrap_s ? '0 : hp_cnt_q + DIV_W'(1);
          if (tick_end_s) begin
            tick_q    <= '0;
            dur_cnt_q <= dur_cnt_q + DUR_W'(1);
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
          if (note_end_s) begin
            spk_q <= 1'b0;
            if (last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              addr_q  <= addr_q + ROM_AW'(1);
              state_q <= ST_LOAD;
            end
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          spk_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          spk_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign speaker_out_o = spk_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer at a scaled clock (CLK_HZ=20000, 20 cycles/tick).
module tb_sound_sequencer;

  localparam int unsigned CLK_HZ  = 20_000;
  localparam int unsigned TICK_HZ = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [1:0] sfx;
`ifdef SFX_MUTE_EN
  logic       mute;
`endif
  logic       busy;
  logic       done;
  logic       spk;

  int checks   = 0;
  int failures = 0;

  bit spk_log [0:20000];
  int busy_cnt, done_n, busy_first, high_cnt;

  sound_sequencer #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .DIV_W   (18),
    .DUR_W   (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .sfx_i         (sfx),
`ifdef SFX_MUTE_EN
    .mute_i        (mute),
`endif
    .busy_o        (busy),
    .done_o        (done),
    .speaker_out_o (spk)
  );

  always #5 clk = ~clk;

  // Starts an effect (req high at the next edge) and logs cycles n=1.. until done.
  // Cycle 1 is the LOAD cycle of the first note. Optionally pulses req mid-run.
  task automatic run_effect(input logic [1:0] s, input int req_at,
                            input logic [1:0] req_s, input int limit);
    busy_cnt = 0; done_n = -1; busy_first = 0; high_cnt = 0;
    spk_log[0] = spk;
    req = 1'b1; sfx = s;
    @(posedge clk);
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req = 1'b0;
        sfx = s ^ 2'b01;
        busy_first = int'(busy);
      end
      if (req_at != 0 && n == req_at) begin req = 1'b1; sfx = req_s; end
      if (req_at != 0 && n == req_at + 1) req = 1'b0;
      spk_log[n] = spk;
      if (busy) busy_cnt++;
      if (spk) high_cnt++;
      if (done) begin
        done_n = n;
        break;
      end
    end
  endtask

  function automatic int first_change(input int from, input int upto);
    if (from < 0) return -1;
    for (int n = from + 1; n <= upto; n++)
      if (spk_log[n] != spk_log[n-1]) return n;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; sfx = 2'd0;
`ifdef SFX_MUTE_EN
    mute = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (spk !== 1'b0) begin failures++; $display("FAIL reset_spk got=%b exp=0", spk); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_place();
    int c1, c2;
    run_effect(2'd0, 0, 2'd0, 3000);
    checks++; if (busy_first !== 1) begin failures++; $display("FAIL place_busy_next got=%0d exp=1", busy_first); end
    checks++; if (done_n !== 1002) begin failures++; $display("FAIL place_done_cycle got=%0d exp=1002", done_n); end
    checks++; if (busy_cnt !== 1001) begin failures++; $display("FAIL place_busy_span got=%0d exp=1001", busy_cnt); end
    c1 = first_change(1, done_n);
    c2 = first_change(c1, done_n);
    checks++; if (c1 !== 21) begin failures++; $display("FAIL place_first_toggle got=%0d exp=21", c1); end
    checks++; if (c2 - c1 !== 19) begin failures++; $display("FAIL place_half_period got=%0d exp=19", c2 - c1); end
    checks++; if (high_cnt !== 494) begin failures++; $display("FAIL place_high_cycles got=%0d exp=494", high_cnt); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL place_done_width got=%b exp=0", done); end
  endtask

  task automatic test_win();
    int starts [4] = '{1, 2002, 4003, 6004};
    int hps    [4] = '{19, 15, 12, 9};
    int c1, c2;
    run_effect(2'd1, 0, 2'd0, 14000);
    checks++; if (done_n !== 12005) begin failures++; $display("FAIL win_done_cycle got=%0d exp=12005", done_n); end
    checks++; if (busy_cnt !== 12004) begin failures++; $display("FAIL win_busy_span got=%0d exp=12004", busy_cnt); end
    for (int i = 0; i < 4; i++) begin
      c1 = first_change(starts[i], done_n);
      c2 = first_change(c1, done_n);
      checks++;
      if (c1 !== starts[i] + hps[i] + 1) begin
        failures++; $display("FAIL win_note%0d_first got=%0d exp=%0d", i, c1, starts[i] + hps[i] + 1);
      end
      checks++;
      if (c2 - c1 !== hps[i]) begin
        failures++; $display("FAIL win_note%0d_half_period got=%0d exp=%0d", i, c2 - c1, hps[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_draw();
    int c1, c2, rest_high;
    run_effect(2'd2, 0, 2'd0, 12000);
    checks++; if (done_n !== 10004) begin failures++; $display("FAIL draw_done_cycle got=%0d exp=10004", done_n); end
    c1 = first_change(1, done_n);
    c2 = first_change(c1, done_n);
    checks++; if (c1 !== 24) begin failures++; $display("FAIL draw_first_toggle got=%0d exp=24", c1); end
    checks++; if (c2 - c1 !== 22) begin failures++; $display("FAIL draw_half_period got=%0d exp=22", c2 - c1); end
    rest_high = 0;
    for (int n = 4002; n <= 6003 && n <= done_n; n++) if (spk_log[n]) rest_high++;
    checks++; if (rest_high !== 0) begin failures++; $display("FAIL draw_rest_high got=%0d exp=0", rest_high); end
    c1 = first_change(4002, done_n);
    checks++; if (c1 !== 6026) begin failures++; $display("FAIL draw_after_rest got=%0d exp=6026", c1); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    run_effect(2'd0, 100, 2'd1, 3000);
    checks++; if (done_n !== 1002) begin failures++; $display("FAIL ignore_done_cycle got=%0d exp=1002", done_n); end
    checks++; if (busy_cnt !== 1001) begin failures++; $display("FAIL ignore_busy_span got=%0d exp=1001", busy_cnt); end
    req = 1'b1; sfx = 2'd3;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fin_req_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL fin_req_done got=%b exp=0", done); end
    run_effect(2'd3, 0, 2'd0, 6000);
    checks++; if (busy_first !== 1) begin failures++; $display("FAIL idle_req_busy got=%0d exp=1", busy_first); end
    checks++; if (done_n !== 5002) begin failures++; $display("FAIL error_done_cycle got=%0d exp=5002", done_n); end
    c1 = first_change(1, done_n);
    c2 = first_change(c1, done_n);
    checks++; if (c1 !== 47) begin failures++; $display("FAIL error_first_toggle got=%0d exp=47", c1); end
    checks++; if (c2 - c1 !== 45) begin failures++; $display("FAIL error_half_period got=%0d exp=45", c2 - c1); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dones, busies;
    req = 1'b1; sfx = 2'd1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (3009) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
    checks++; if (spk !== 1'b1) begin failures++; $display("FAIL mid_spk got=%b exp=1", spk); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", done); end
    checks++; if (spk !== 1'b0) begin failures++; $display("FAIL rst_mid_spk got=%b exp=0", spk); end
    dones = 0; busies = 0;
    for (int n = 0; n < 13000; n++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busies++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL rst_mid_late_done got=%0d exp=0", dones); end
    checks++; if (busies !== 0) begin failures++; $display("FAIL rst_mid_late_busy got=%0d exp=0", busies); end
  endtask

`ifdef SFX_MUTE_EN
  task automatic test_mute();
    mute = 1'b1;
    run_effect(2'd3, 0, 2'd0, 6000);
    checks++; if (high_cnt !== 0) begin failures++; $display("FAIL mute_high_cycles got=%0d exp=0", high_cnt); end
    checks++; if (done_n !== 5002) begin failures++; $display("FAIL mute_done_cycle got=%0d exp=5002", done_n); end
    checks++; if (busy_cnt !== 5001) begin failures++; $display("FAIL mute_busy_span got=%0d exp=5001", busy_cnt); end
    mute = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_place();
    test_win();
    test_draw();
    test_back_to_back();
    test_reset_mid();
`ifdef SFX_MUTE_EN
    test_mute();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
